// File: rtl/spi_slave_burst_pkg.sv
// Shared types and defaults for the SPI-RAM slave front-end.
// Optional streaming mode is selected by SPI_BURST_EN (see spi_slave_burst).
package spi_slave_burst_pkg;
   localparam int MEM_WIDTH_DEF = 8;
   localparam int MAX_WAIT_DEF  = 16;

   localparam logic [1:0] WR_ADDR = 2'b00;
   localparam logic [1:0] WR_DATA = 2'b01;
   localparam logic [1:0] RD_ADDR = 2'b10;
   localparam logic [1:0] RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_SHIFT, DONE
   } state_t;
endpackage

// File: rtl/spi_shift_reg.sv
// Parametrised shift register: serial-in/parallel-out and parallel-in/serial-out.
// Shifts toward the MSB; clear wins over load, load wins over shift.
module spi_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic         i_sin,
   input  logic [W-1:0] i_pdata,
   output logic [W-1:0] o_pdata
);
   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst || i_clr)  r_q <= '0;
      else if (i_load)   r_q <= i_pdata;
      else if (i_shift)  r_q <= {r_q[W-2:0], i_sin};
   end

   assign o_pdata = r_q;
endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front-end for the SPI-RAM: deserialises cmd+data frames, serialises read data.
// Define SPI_BURST_EN to accept back-to-back frames inside one SS_n-low window.
module spi_slave_burst
   import spi_slave_burst_pkg::*;
#(
   parameter int MEM_WIDTH = MEM_WIDTH_DEF,
   parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SS_n,
   input  logic                 MOSI,
   input  logic                 tx_valid,
   input  logic [MEM_WIDTH-1:0] tx_data,
   output logic                 MISO,
   output logic                 rx_valid,
   output logic [MEM_WIDTH+1:0] rx_data,
   output logic                 busy,
   output logic                 err
);
   localparam int FRAME = MEM_WIDTH + 2;
   localparam int CNT_W = $clog2(FRAME + MAX_WAIT + 1);
`ifdef SPI_BURST_EN
   localparam state_t S_CMPL = CHK_CMD;
`else
   localparam state_t S_CMPL = DONE;
`endif

   state_t               r_state, w_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_rd_addr_seen, r_rx_valid, r_err;
   logic [FRAME-1:0]     r_rx_data;
   logic [FRAME-2:0]     w_rx_q;
   logic [MEM_WIDTH-1:0] w_tx_q;
   logic w_cnt_st, w_last_bit, w_last_shift, w_timeout;
   logic w_rx_shift, w_frame_done, w_tx_load, w_tx_shift, w_tx_clr, w_err_set;

   assign w_cnt_st     = r_state inside {WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_SHIFT};
   assign w_last_bit   = (r_cnt == CNT_W'(FRAME - 2));
   assign w_last_shift = (r_cnt == CNT_W'(MEM_WIDTH - 1));
   assign w_timeout    = (r_cnt == CNT_W'(MAX_WAIT - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nxt;
   end

   // SS_n high anywhere outside IDLE aborts the transfer.
   always_comb begin
      w_nxt = r_state;
      if (SS_n) w_nxt = IDLE;
      else begin
         case (r_state)
            IDLE:     w_nxt = CHK_CMD;
            CHK_CMD:  if (MOSI != RD_ADDR[1]) w_nxt = WRITE;
                      else if (r_rd_addr_seen) w_nxt = READ_DATA;
                      else                     w_nxt = READ_ADD;
            WRITE, READ_ADD: if (w_last_bit) w_nxt = S_CMPL;
            READ_DATA: if (w_last_bit) w_nxt = RD_WAIT;
            RD_WAIT:  if (tx_valid) w_nxt = RD_SHIFT;
                      else if (w_timeout) w_nxt = DONE;
            RD_SHIFT: if (w_last_shift) w_nxt = S_CMPL;
            default:  ;
         endcase
      end
   end

   always_comb begin
      w_rx_shift   = 1'b0;
      w_frame_done = 1'b0;
      w_tx_load    = 1'b0;
      w_tx_shift   = 1'b0;
      w_err_set    = 1'b0;
      w_tx_clr     = SS_n;
      if (!SS_n) begin
         case (r_state)
            CHK_CMD: w_rx_shift = 1'b1;
            WRITE, READ_ADD, READ_DATA: begin
               w_rx_shift   = 1'b1;
               w_frame_done = w_last_bit;
            end
            RD_WAIT: begin
               w_tx_load = tx_valid;
               w_err_set = !tx_valid && w_timeout;
            end
            RD_SHIFT: w_tx_shift = 1'b1;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt          <= '0;
         r_rx_valid     <= 1'b0;
         r_err          <= 1'b0;
         r_rx_data      <= '0;
         r_rd_addr_seen <= 1'b0;
      end else begin
         r_rx_valid <= w_frame_done;
         r_err      <= w_err_set;
         if (w_frame_done) begin
            r_rx_data <= {w_rx_q, MOSI};
            if (r_state == READ_ADD)       r_rd_addr_seen <= 1'b1;
            else if (r_state == READ_DATA) r_rd_addr_seen <= 1'b0;
         end
         // Counter restarts on every state entry.
         if (w_nxt != r_state || !w_cnt_st) r_cnt <= '0;
         else                               r_cnt <= r_cnt + 1'b1;
      end
   end

   spi_shift_reg #(.W(FRAME-1)) u_rx_sr (
      .clk(clk), .rst(rst), .i_clr(1'b0), .i_load(1'b0), .i_shift(w_rx_shift),
      .i_sin(MOSI), .i_pdata('0), .o_pdata(w_rx_q)
   );

   // Shifting zeros in leaves MISO low once the LSB period ends.
   spi_shift_reg #(.W(MEM_WIDTH)) u_tx_sr (
      .clk(clk), .rst(rst), .i_clr(w_tx_clr), .i_load(w_tx_load), .i_shift(w_tx_shift),
      .i_sin(1'b0), .i_pdata(tx_data), .o_pdata(w_tx_q)
   );

   assign MISO     = w_tx_q[MEM_WIDTH-1];
   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign err      = r_err;
   assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_spi_slave_burst.sv
// Self-checking bench for spi_slave_burst (MEM_WIDTH=8, MAX_WAIT=16), directed plus random frames.
// Burst expectations follow SPI_BURST_EN when it is defined for the build.
module tb_spi_slave_burst;
   localparam int MW = 16;

   logic       clk = 1'b0;
   logic       rst, SS_n, MOSI, tx_valid;
   logic [7:0] tx_data;
   logic       MISO, rx_valid, busy, err;
   logic [9:0] rx_data;
   int         errors = 0;
   int         checks = 0;
   bit         m_seen;   // model: a read-address frame is pending its read-data frame

   always #5 clk = ~clk;

   spi_slave_burst #(.MEM_WIDTH(8), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .tx_valid(tx_valid),
      .tx_data(tx_data), .MISO(MISO), .rx_valid(rx_valid), .rx_data(rx_data),
      .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge_(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
      @(negedge clk);
      SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
      @(posedge clk); #1;
   endtask

   task automatic ss_high(input string tag);
      edge_(1'b1, 1'($urandom), 1'b0, 8'h00);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_miso0"}, MISO, 0);
   endtask

   // Edge 0 plus ten frame bits; rx_valid only after the tenth bit.
   task automatic frame(input logic [9:0] f, input string tag, output bit is_rd);
      is_rd = f[9] && m_seen;
      edge_(1'b0, 1'b0, 1'b0, 8'h00);
      chk({tag, "_busy"}, busy, 1);
      for (int i = 9; i >= 0; i--) begin
         edge_(1'b0, f[i], 1'b0, 8'h00);
         chk({tag, "_rxv"}, rx_valid, (i == 0));
      end
      chk({tag, "_rxd"}, rx_data, f);
      if (f[9]) m_seen = !m_seen;
   endtask

   task automatic rd_wait(input int dly, input logic [7:0] d, input bit tmo);
      if (tmo) begin
         for (int k = 1; k <= MW; k++) begin
            edge_(1'b0, 1'($urandom), 1'b0, 8'($urandom));
            chk("tmo_err", err, (k == MW));
            chk("tmo_miso", MISO, 0);
         end
         edge_(1'b0, 1'($urandom), 1'b0, 8'($urandom));
         chk("tmo_err_once", err, 0);
      end else begin
         for (int k = 0; k < dly; k++) begin
            edge_(1'b0, 1'($urandom), 1'b0, 8'($urandom));
            chk("wait_miso", MISO, 0);
            chk("wait_err", err, 0);
         end
         edge_(1'b0, 1'($urandom), 1'b1, d);
         chk("miso_msb", MISO, d[7]);
         for (int b = 6; b >= 0; b--) begin
            edge_(1'b0, 1'($urandom), 1'b0, 8'($urandom));
            chk("miso_bit", MISO, d[b]);
         end
         edge_(1'b0, 1'($urandom), 1'b0, 8'($urandom));
         chk("miso_tail", MISO, 0);
      end
   endtask

   initial begin
      bit         rd;
      logic [9:0] f;
      logic [19:0] bw;
      rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      m_seen = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_miso", MISO, 0);
      chk("rst_rxv", rx_valid, 0);
      chk("rst_rxd", rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      @(negedge clk); rst = 1'b0;

      // Write address, then trailing bits that must not produce another frame
      frame(10'h0A5, "wr_addr", rd);
      for (int i = 0; i < 3; i++) begin
         edge_(1'b0, 1'($urandom), 1'b0, 8'h00);
         chk("wr_trail_rxv", rx_valid, 0);
         chk("wr_trail_busy", busy, 1);
      end
      ss_high("wr_end");

      // Read address + read data, data arrives after a short wait
      frame(10'h203, "rd_addr", rd);
      chk("rd_addr_kind", rd, 0);
      ss_high("rd_addr_end");
      frame(10'h300, "rd_data", rd);
      chk("rd_data_kind", rd, 1);
      rd_wait(2, 8'hC3, 1'b0);
      ss_high("rd_end");

      // Timeout
      frame(10'h2F0, "to_addr", rd);
      ss_high("to_addr_end");
      frame(10'h300, "to_data", rd);
      rd_wait(0, 8'h00, 1'b1);
      ss_high("to_end");

      // Abort after 5 bits, then a full frame
      edge_(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         edge_(1'b0, 1'($urandom), 1'b0, 8'h00);
         chk("abort_rxv", rx_valid, 0);
      end
      ss_high("abort");
      chk("abort_rxv_end", rx_valid, 0);
      frame(10'h15A, "post_abort", rd);
      ss_high("post_abort_end");

      // Reset in the middle of the read shift-out
      frame(10'h2AA, "mr_addr", rd);
      ss_high("mr_addr_end");
      frame(10'h355, "mr_data", rd);
      edge_(1'b0, 1'b0, 1'b1, 8'h96);
      chk("mr_msb", MISO, 1);
      for (int i = 0; i < 3; i++) edge_(1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("mr_miso", MISO, 0);
      chk("mr_rxv", rx_valid, 0);
      chk("mr_rxd", rx_data, 0);
      chk("mr_busy", busy, 0);
      chk("mr_err", err, 0);
      @(negedge clk); rst = 1'b0; SS_n = 1'b1;
      m_seen = 1'b0;
      frame(10'h2F0, "mr_next", rd);
      chk("mr_next_kind", rd, 0);
      edge_(1'b0, 1'b0, 1'b1, 8'hFF);
      chk("mr_txv_ignored", MISO, 0);
      ss_high("mr_next_end");
      frame(10'h300, "mr_rd", rd);
      chk("mr_rd_kind", rd, 1);
      rd_wait(1, 8'h5A, 1'b0);
      ss_high("mr_rd_end");

      // Two frames in one SS_n window
      bw = {10'h012, 10'h134};
      edge_(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 19; i >= 0; i--) begin
         edge_(1'b0, bw[i], 1'b0, 8'h00);
`ifdef SPI_BURST_EN
         chk("burst_rxv", rx_valid, (i == 10 || i == 0));
         if (i == 0) chk("burst_rxd1", rx_data, 10'h134);
`else
         chk("burst_rxv", rx_valid, (i == 10));
`endif
         if (i == 10) chk("burst_rxd0", rx_data, 10'h012);
      end
      ss_high("burst_end");

      // Random frames against the transaction-level model
      for (int n = 0; n < 12; n++) begin
         f = 10'($urandom);
         frame(f, "rnd", rd);
         if (rd) rd_wait(int'($urandom_range(0, MW - 2)), 8'($urandom),
                         ($urandom_range(0, 3) == 0));
         ss_high("rnd_end");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
